spi_chain_ctrl: RTL and testbench

SPI_CHAIN_CTRL -- requirements
Module: spi_chain_ctrl

---
 rtl/spi_chain_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_chain_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_chain_ctrl.sv
// SPI mode-0 master for a daisy chain of N_DEV 8-bit devices sharing one select.
// One frame: select low, DIV-cycle setup, 8*N_DEV sclk periods, DIV-cycle hold,
// then a single DONE cycle that publishes the received frame.
module spi_chain_ctrl #(
   parameter int unsigned N_DEV = 4,
   parameter int unsigned DIV   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [8*N_DEV-1:0]   tx_data,
   output logic                 busy,
   output logic                 done,
   output logic [8*N_DEV-1:0]   rx_data,
   output logic                 sclk,
   output logic                 ss,
   output logic                 mosi,
   input  logic                 miso
);

   localparam int unsigned FW = 8 * N_DEV;
   localparam int unsigned BW = $clog2(FW + 1);
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   bit_cnt;
   // bits still to be sent after the one currently on mosi
   logic [FW-2:0]   tx_shift;
   logic [FW-1:0]   rx_shift;

   logic            in_frame;
   logic            accept;
   logic            half_end;
   logic            setup_end;
   logic            fall_evt;
   logic            low_end;
   logic            last_bit;
   logic            rise_evt;

   logic            sclk_nxt;
   logic            ss_nxt;
   logic            busy_nxt;
   logic            done_nxt;

   // Timing events derived from the half-period divider and the sclk phase.
   assign in_frame  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
   assign accept    = (state == IDLE) && start;
   assign half_end  = (div_cnt == DW'(DIV - 1));
   assign setup_end = (state == SETUP) && half_end;
   assign fall_evt  = (state == SHIFT) && half_end && sclk;
   assign low_end   = (state == SHIFT) && half_end && !sclk;
   assign last_bit  = (bit_cnt == BW'(FW));
   assign rise_evt  = setup_end || (low_end && !last_bit);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)              next_state = SETUP;
         SETUP:   if (half_end)           next_state = SHIFT;
         SHIFT:   if (low_end && last_bit) next_state = HOLD;
         HOLD:    if (half_end)           next_state = DONE;
         DONE:                            next_state = IDLE;
         default:                         next_state = IDLE;
      endcase
   end

   // Next values of the registered control outputs, decoded from the next state.
   always_comb begin
      sclk_nxt = 1'b0;
      ss_nxt   = 1'b1;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      if (next_state == SHIFT) begin
         if (rise_evt) begin
            sclk_nxt = 1'b1;
         end else if (fall_evt) begin
            sclk_nxt = 1'b0;
         end else begin
            sclk_nxt = sclk;
         end
      end
      if ((next_state == SETUP) || (next_state == SHIFT) || (next_state == HOLD)) begin
         ss_nxt   = 1'b0;
         busy_nxt = 1'b1;
      end
      if (next_state == DONE) begin
         done_nxt = 1'b1;
      end
   end

   // Control output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk <= 1'b0;
         ss   <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         sclk <= sclk_nxt;
         ss   <= ss_nxt;
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Divider, bit counter and shift registers; rx_data only moves on entry to DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         mosi     <= 1'b0;
         rx_data  <= '0;
      end else begin
         if (in_frame && !half_end) begin
            div_cnt <= div_cnt + DW'(1);
         end else begin
            div_cnt <= '0;
         end

         if (accept) begin
            tx_shift <= tx_data[FW-2:0];
            mosi     <= tx_data[FW-1];
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else begin
            if (fall_evt) begin
               mosi     <= tx_shift[FW-2];
               tx_shift <= {tx_shift[FW-3:0], 1'b0};
               bit_cnt  <= bit_cnt + BW'(1);
            end
            if (rise_evt) begin
               rx_shift <= {rx_shift[FW-2:0], miso};
            end
         end

         if (next_state == DONE) begin
            rx_data <= rx_shift;
         end
      end
   end

endmodule

// File: tb/tb_spi_chain_ctrl.sv
// Scoreboard bench for spi_chain_ctrl: frames are queued with their expected
// timing and data when issued; a negedge monitor checks every cycle against them.
module tb_spi_chain_ctrl;

   localparam int unsigned N_DEV     = 2;
   localparam int unsigned DIV       = 2;
   localparam int unsigned FW        = 8 * N_DEV;
   localparam int          FRAME_LEN = 1 + DIV + 2 * DIV * FW + DIV + 1;

   typedef struct {
      int            p;   // posedge index at which start is accepted
      int            d;   // posedge index after which done is high
      logic [FW-1:0] tx;
      logic [FW-1:0] rx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [FW-1:0] tx_data;
   logic          busy;
   logic          done;
   logic [FW-1:0] rx_data;
   logic          sclk;
   logic          ss;
   logic          mosi;
   logic          miso;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spi_chain_ctrl #(.N_DEV(N_DEV), .DIV(DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sclk    (sclk),
      .ss      (ss),
      .mosi    (mosi),
      .miso    (miso)
   );

   // Slave side: present miso_word MSB first, advancing after each sclk fall.
   logic [FW-1:0] miso_word = '0;
   logic [FW-1:0] miso_sr   = '0;
   logic          drv_prev_sclk = 1'b0;
   bit            loop_en = 1'b0;

   always @(negedge clk) begin
      if (ss !== 1'b0) miso_sr <= miso_word;
      else if (drv_prev_sclk && !sclk) miso_sr <= {miso_sr[FW-2:0], 1'b0};
      drv_prev_sclk <= sclk;
   end

   assign miso = loop_en ? mosi : miso_sr[FW-1];

   // Scoreboard and counters.
   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;
   int   rst_req = 0;
   int   rst_seen = 0;
   int   next_ok = 0;

   logic          prev_sclk = 1'b0;
   logic          prev_ss = 1'b1;
   logic [FW-1:0] mosi_word = '0;
   int            rises = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, want, cyc);
   endfunction

   // Monitor: compare DUT outputs each cycle against the queued frames.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_ss && !ss) begin
            mosi_word = '0;
            rises     = 0;
         end
         if (!prev_sclk && sclk) begin
            mosi_word = {mosi_word[FW-2:0], mosi};
            rises++;
         end
         if (rst_req != rst_seen) begin
            chk("reset_ctrl", 64'({sclk, ss, mosi, busy, done}), 64'(5'b01000));
            chk("reset_rx", 64'(rx_data), 64'd0);
            rst_seen = rst_req;
         end
         if (q.size() > 0 && cyc == q[0].d) begin
            chk("done_cycle", 64'({busy, ss, done, sclk}), 64'(4'b0110));
            chk("rx_data", 64'(rx_data), 64'(q[0].rx));
            chk("mosi_frame", 64'(mosi_word), 64'(q[0].tx));
            chk("sclk_rises", 64'(rises), 64'(FW));
            void'(q.pop_front());
         end else if (q.size() > 0 && cyc >= q[0].p) begin
            chk("in_frame", 64'({busy, ss, done}), 64'(3'b100));
         end else begin
            chk("idle", 64'({busy, ss, done, sclk}), 64'(4'b0100));
         end
      end
      prev_sclk = sclk;
      prev_ss   = ss;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      while (cyc + 1 < next_ok) tick();
   endtask

   // Issue one frame; the model accepts starts only FRAME_LEN cycles apart.
   task automatic issue(input logic [FW-1:0] tx, input logic [FW-1:0] mw,
                        input bit lp, output int p);
      wait_ready();
      tx_data   = tx;
      miso_word = mw;
      loop_en   = lp;
      start     = 1'b1;
      p         = cyc + 1;
      q.push_back('{p: p, d: p + FRAME_LEN - 2, tx: tx, rx: (lp ? tx : mw)});
      next_ok   = p + FRAME_LEN;
      tick();
      start     = 1'b0;
      tx_data   = FW'($urandom);
   endtask

   // Start held high: frames repeat with one IDLE cycle between them.
   task automatic held(input int n);
      int p;
      wait_ready();
      loop_en = 1'b1;
      tx_data = FW'($urandom);
      start   = 1'b1;
      p       = cyc + 1;
      for (int i = 0; i < n; i++) begin
         q.push_back('{p: p, d: p + FRAME_LEN - 2, tx: tx_data, rx: tx_data});
         next_ok = p + FRAME_LEN;
         while (cyc < p) tick();
         tx_data = FW'($urandom);
         if (i < n - 1) p = p + FRAME_LEN;
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int p;
      // Reset with start asserted: reset must win.
      rst     = 1'b0;
      start   = 1'b1;
      tx_data = FW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b1;
      start   = 1'b0;
      mon_en  = 1'b1;
      rst_req++;
      next_ok = cyc + 1;

      // Loopback of a known pattern.
      issue(FW'(16'hA55A), '0, 1'b1, p);

      // Known miso pattern.
      issue(FW'($urandom), FW'(16'h3CC3), 1'b0, p);

      // Second start mid-SHIFT is ignored.
      issue(FW'($urandom), FW'($urandom), 1'b0, p);
      while (cyc < p + 8 * DIV) tick();
      start = 1'b1;
      tick();
      start = 1'b0;

      // Reset during bit 5 aborts the frame.
      issue(FW'($urandom), FW'($urandom), 1'b0, p);
      while (cyc < p + DIV + 2 * DIV * 5 + 1) tick();
      rst = 1'b0;
      tick();
      q.delete();
      rst = 1'b1;
      rst_req++;
      next_ok = cyc + 1;

      // Frame after the abort completes normally.
      issue(FW'($urandom), FW'($urandom), 1'b0, p);

      // Back-to-back frames with start held high.
      held(3);

      // Randomized frames with random gaps.
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         issue(FW'($urandom), FW'($urandom), 1'($urandom_range(0, 1)), p);
      end

      repeat (FRAME_LEN + 4) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
